// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and ALU operation encoding for the core.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam int F7_SUB_BIT = 5;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // One-hot order: {add, sub, xor, or, and}
  function automatic logic [4:0] alu_onehot(input alu_op_e op);
    logic [4:0] oh;
    oh = 5'b10000;
    case (op)
      ALU_ADD: oh = 5'b10000;
      ALU_SUB: oh = 5'b01000;
      ALU_XOR: oh = 5'b00100;
      ALU_OR:  oh = 5'b00010;
      ALU_AND: oh = 5'b00001;
      default: oh = 5'b10000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two async read ports, one sync write port, x0 hardwired to zero.
// ID_WB_BYPASS_EN: when defined, a same-cycle write to a read index is forwarded.
module regfile
  import riscv_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int NR = NREGS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  input  logic         we,
  input  logic [4:0]   wa,
  input  logic [W-1:0] wd
);

  logic [W-1:0] mem [NR];
  logic         wr_ok;

  assign wr_ok = we && (wa != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) rd1 = mem[ra1];
    if (ra2 != 5'd0) rd2 = mem[ra2];
`ifdef ID_WB_BYPASS_EN
    if (wr_ok && (wa == ra1)) rd1 = wd;
    if (wr_ok && (wa == ra2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// RV32 decode stage: register file, subset decode, and ALU loopback tracking.
// Regfile write-through is enabled by defining ID_WB_BYPASS_EN.
module id_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            alu_rs2_reg,
  output logic [XLEN-1:0] imm,
  output logic            add_en,
  output logic            sub_en,
  output logic            xor_en,
  output logic            or_en,
  output logic            and_en,
  output logic            rs1_alu_loopback,
  output logic            rs2_alu_loopback,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [4:0] f_rd, f_rs1, f_rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign f_rd   = instr[11:7];
  assign funct3 = instr[14:12];
  assign f_rs1  = instr[19:15];
  assign f_rs2  = instr[24:20];
  assign funct7 = instr[31:25];

  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [4:0]      last_rd;

  regfile #(.W(XLEN), .NR(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (f_rs1),
    .ra2 (f_rs2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  logic    dec_illegal;
  logic    is_op, is_op_imm, is_lui;
  alu_op_e alu_op;

  localparam logic [6:0] F7_SUB = 7'(1 << F7_SUB_BIT);

  always_comb begin
    dec_illegal = 1'b1;
    is_op       = 1'b0;
    is_op_imm   = 1'b0;
    is_lui      = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        is_op = 1'b1;
        case (funct3)
          F3_ADD: begin
            if (funct7 == 7'd0) begin
              dec_illegal = 1'b0;
              alu_op      = ALU_ADD;
            end else if (funct7 == F7_SUB) begin
              dec_illegal = 1'b0;
              alu_op      = ALU_SUB;
            end
          end
          F3_XOR: if (funct7 == 7'd0) begin dec_illegal = 1'b0; alu_op = ALU_XOR; end
          F3_OR:  if (funct7 == 7'd0) begin dec_illegal = 1'b0; alu_op = ALU_OR;  end
          F3_AND: if (funct7 == 7'd0) begin dec_illegal = 1'b0; alu_op = ALU_AND; end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        is_op_imm = 1'b1;
        case (funct3)
          F3_ADD: begin dec_illegal = 1'b0; alu_op = ALU_ADD; end
          F3_XOR: begin dec_illegal = 1'b0; alu_op = ALU_XOR; end
          F3_OR:  begin dec_illegal = 1'b0; alu_op = ALU_OR;  end
          F3_AND: begin dec_illegal = 1'b0; alu_op = ALU_AND; end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        is_lui      = 1'b1;
        dec_illegal = 1'b0;
        alu_op      = ALU_ADD;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic issue;
  assign issue   = rst && instr_valid && !stall && !dec_illegal;
  assign illegal = rst && instr_valid && dec_illegal;

  logic [4:0] en_oh;
  assign en_oh = alu_onehot(alu_op);

  always_comb begin
    rd_addr          = 5'd0;
    rs1              = '0;
    rs2              = '0;
    alu_rs2_reg      = 1'b0;
    imm              = '0;
    {add_en, sub_en, xor_en, or_en, and_en} = 5'b10000;
    rs1_alu_loopback = 1'b0;
    rs2_alu_loopback = 1'b0;
    if (issue) begin
      rd_addr = f_rd;
      {add_en, sub_en, xor_en, or_en, and_en} = en_oh;
      if (is_op) begin
        rs1         = rf_rd1;
        rs2         = rf_rd2;
        alu_rs2_reg = 1'b1;
      end else if (is_op_imm) begin
        rs1 = rf_rd1;
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end else if (is_lui) begin
        imm = {instr[31:12], 12'h000};
      end
      // LUI never reads rs1, so it cannot loop back
      rs1_alu_loopback = (is_op || is_op_imm) && (last_rd != 5'd0) && (f_rs1 == last_rd);
      rs2_alu_loopback = is_op && (last_rd != 5'd0) && (f_rs2 == last_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_rd <= 5'd0;
    else      last_rd <= rd_addr;
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: table of per-cycle vectors plus reset and bypass sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rs1, rs2, imm;
  logic        alu_rs2_reg, add_en, sub_en, xor_en, or_en, and_en;
  logic        rs1_alu_loopback, rs2_alu_loopback, illegal;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr(rd_addr), .rs1(rs1), .rs2(rs2), .alu_rs2_reg(alu_rs2_reg), .imm(imm),
    .add_en(add_en), .sub_en(sub_en), .xor_en(xor_en), .or_en(or_en), .and_en(and_en),
    .rs1_alu_loopback(rs1_alu_loopback), .rs2_alu_loopback(rs2_alu_loopback),
    .illegal(illegal)
  );

  localparam logic [4:0] EN_ADD = 5'b10000, EN_SUB = 5'b01000, EN_XOR = 5'b00100,
                         EN_OR  = 5'b00010, EN_AND = 5'b00001;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [109:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic logic [109:0] mk(input logic [4:0] rd, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic alu,
                                      input logic [31:0] im, input logic [4:0] en,
                                      input logic lb1, input logic lb2, input logic ill);
    return {rd, r1, r2, alu, im, en, lb1, lb2, ill};
  endfunction

  function automatic logic [109:0] bub(input logic ill);
    return mk(5'd0, 32'd0, 32'd0, 1'b0, 32'd0, EN_ADD, 1'b0, 1'b0, ill);
  endfunction

  task automatic check(input string name, input logic [109:0] exp);
    logic [109:0] act;
    act = {rd_addr, rs1, rs2, alu_rs2_reg, imm, add_en, sub_en, xor_en, or_en, and_en,
           rs1_alu_loopback, rs2_alu_loopback, illegal};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic v, input logic s, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    instr = i; instr_valid = v; stall = s; wb_en = we; wb_addr = wa; wb_data = wd;
    #3;
  endtask

  vec_t vecs[17];
  logic [31:0] byp_exp;

  initial begin
    vecs[0]  = '{"wb_x5",      32'h0000_0000, 0, 0, 1, 5'd5, 32'h1234, bub(0)};
    vecs[1]  = '{"addi_x6",    32'hFFF2_8313, 1, 0, 1, 5'd1, 32'h11,
                 mk(5'd6, 32'h1234, 32'd0, 0, 32'hFFFF_FFFF, EN_ADD, 0, 0, 0)};
    vecs[2]  = '{"wb_x2",      32'h0000_0000, 0, 0, 1, 5'd2, 32'h22, bub(0)};
    vecs[3]  = '{"add_x3",     32'h0020_81B3, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd3, 32'h11, 32'h22, 1, 32'd0, EN_ADD, 0, 0, 0)};
    vecs[4]  = '{"sub_loop",   32'h4031_8233, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd4, 32'd0, 32'd0, 1, 32'd0, EN_SUB, 1, 1, 0)};
    vecs[5]  = '{"add_x3_b",   32'h0020_81B3, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd3, 32'h11, 32'h22, 1, 32'd0, EN_ADD, 0, 0, 0)};
    vecs[6]  = '{"stall",      32'h0011_C233, 1, 1, 0, 5'd0, 32'h0, bub(0)};
    vecs[7]  = '{"xor_nolb",   32'h0011_C233, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd4, 32'd0, 32'h11, 1, 32'd0, EN_XOR, 0, 0, 0)};
    vecs[8]  = '{"wb_x0",      32'h0000_0000, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, bub(0)};
    vecs[9]  = '{"or_x0",      32'h0000_6533, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd10, 32'd0, 32'd0, 1, 32'd0, EN_OR, 0, 0, 0)};
    vecs[10] = '{"lui",        32'hABC5_05B7, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd11, 32'd0, 32'd0, 0, 32'hABC5_0000, EN_ADD, 0, 0, 0)};
    vecs[11] = '{"andi_lb",    32'h0F05_F613, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd12, 32'd0, 32'd0, 0, 32'h0000_00F0, EN_AND, 1, 0, 0)};
    vecs[12] = '{"load_ill",   32'h0006_2683, 1, 0, 0, 5'd0, 32'h0, bub(1)};
    vecs[13] = '{"sll_stall",  32'h0020_9133, 1, 1, 0, 5'd0, 32'h0, bub(1)};
    vecs[14] = '{"ori_neg",    32'h8000_E713, 1, 0, 0, 5'd0, 32'h0,
                 mk(5'd14, 32'h11, 32'd0, 0, 32'hFFFF_F800, EN_OR, 0, 0, 0)};
    vecs[15] = '{"mul_ill",    32'h0220_81B3, 1, 0, 0, 5'd0, 32'h0, bub(1)};
    vecs[16] = '{"inv_novld",  32'h0006_2683, 0, 0, 0, 5'd0, 32'h0, bub(0)};

    instr = 32'h0006_2683; instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bubble", bub(0));
    #2;
    rst = 1'b1; instr_valid = 1'b0;

    for (int k = 0; k < 17; k++) begin
      step(vecs[k].instr, vecs[k].valid, vecs[k].stall, vecs[k].wb_en,
           vecs[k].wb_addr, vecs[k].wb_data);
      check(vecs[k].name, vecs[k].exp);
    end

`ifdef ID_WB_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h33;
`endif
    step(32'h0, 0, 0, 1, 5'd7, 32'h33);
    check("wb_x7_old", bub(0));
    step(32'h0073_E433, 1, 0, 1, 5'd7, 32'h55);
    check("bypass_or", mk(5'd8, byp_exp, byp_exp, 1, 32'd0, EN_OR, 0, 0, 0));
    step(32'h0073_84B3, 1, 0, 0, 5'd0, 32'h0);
    check("after_wb_x7", mk(5'd9, 32'h55, 32'h55, 1, 32'd0, EN_ADD, 0, 0, 0));

    step(32'h0020_81B3, 1, 0, 0, 5'd0, 32'h0);
    check("pre_rst_add", mk(5'd3, 32'h11, 32'h22, 1, 32'd0, EN_ADD, 0, 0, 0));
    #1;
    rst = 1'b0;
    #1;
    check("midrst_bubble", bub(0));
    instr = 32'h0006_2683;
    #1;
    check("midrst_noill", bub(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    instr = 32'h0051_82B3; instr_valid = 1'b1; stall = 1'b0; wb_en = 1'b0;
    #3;
    check("post_rst_add", mk(5'd5, 32'd0, 32'd0, 1, 32'd0, EN_ADD, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
